// File: rtl/digit_step_sequencer.sv
// Step engine for the 0..MAX_DIGIT HEX0 counter: prescaled up/down/ping-pong
// runs plus single steps, with a shadow of the digit for boundary detection.
module digit_step_sequencer #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic       stop,
  input  logic       step_req,
  input  logic       dir_in,
  output logic       step_en,
  output logic       dir,
  output logic [3:0] digit,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned    CW    = $clog2(DIV);
  localparam logic [CW-1:0]  LAST  = CW'(DIV - 1);
  localparam logic [3:0]     MAX_D = 4'(MAX_DIGIT);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_PING = 2'b10,
    M_RSVD = 2'b11
  } mode_t;

  state_t        state, state_n;
  mode_t         run_mode, run_mode_n;
  logic [CW-1:0] count, count_n;
  logic [3:0]    digit_n, nd;
  logic          dir_n, step_en_n, wrap_n;

  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic up);
    if (up) return (d == MAX_D) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? MAX_D : d - 4'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      run_mode <= M_UP;
      count    <= '0;
      digit    <= '0;
      dir      <= 1'b1;
      step_en  <= 1'b0;
      wrap     <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_n;
      run_mode <= run_mode_n;
      count    <= count_n;
      digit    <= digit_n;
      dir      <= dir_n;
      step_en  <= step_en_n;
      wrap     <= wrap_n;
      running  <= (state_n == S_RUN);
    end
  end

  always_comb begin
    state_n    = state;
    run_mode_n = run_mode;
    count_n    = count;
    digit_n    = digit;
    dir_n      = dir;
    step_en_n  = 1'b0;
    wrap_n     = 1'b0;
    nd         = '0;
    case (state)
      S_IDLE: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (start) begin
          state_n    = S_RUN;
          run_mode_n = mode_t'(mode);
          count_n    = '0;
          case (mode_t'(mode))
            M_DOWN:  dir_n = 1'b0;
            // Starting ping-pong at the top must head down immediately.
            M_PING:  dir_n = (digit != MAX_D);
            default: dir_n = 1'b1;
          endcase
        end else if (step_req) begin
          nd        = next_digit(digit, dir_in);
          step_en_n = 1'b1;
          dir_n     = dir_in;
          digit_n   = nd;
          wrap_n    = dir_in ? (nd == 4'd0) : (nd == MAX_D);
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
          count_n = '0;
        end else if (count == LAST) begin
          count_n   = '0;
          step_en_n = 1'b1;
          nd        = next_digit(digit, dir);
          digit_n   = nd;
          if (run_mode == M_PING) begin
            if (dir && (nd == MAX_D)) begin
              dir_n  = 1'b0;
              wrap_n = 1'b1;
            end else if (!dir && (nd == 4'd0)) begin
              dir_n  = 1'b1;
              wrap_n = 1'b1;
            end
          end else begin
            wrap_n = dir ? (nd == 4'd0) : (nd == MAX_D);
          end
        end else begin
          count_n = count + CW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_digit_step_sequencer.sv
// Directed bench for digit_step_sequencer (DIV=4, MAX_DIGIT=9).
module tb_digit_step_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic       start, stop, step_req, dir_in;
  logic       step_en, dir, running, wrap;
  logic [3:0] digit;

  int n_checks = 0;
  int n_fail   = 0;

  digit_step_sequencer #(.DIV(4), .MAX_DIGIT(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
    .step_req (step_req),
    .dir_in   (dir_in),
    .step_en  (step_en),
    .dir      (dir),
    .digit    (digit),
    .running  (running),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Three quiet cycles, then a step pulse carrying the given digit/wrap/dir.
  task automatic expect_step(input logic [3:0] d, input logic w, input logic dr, input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk({tag, "_quiet"}, step_en, 1'b0);
    end
    cyc();
    chk({tag, "_step_en"}, step_en, 1'b1);
    chk({tag, "_digit"}, digit, d);
    chk({tag, "_wrap"}, wrap, w);
    chk({tag, "_dir"}, dir, dr);
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; start = 1'b0; stop = 1'b0; step_req = 1'b0; dir_in = 1'b0;
    #1;
    chk("rst_digit", digit, 4'd0);
    chk("rst_dir", dir, 1'b1);
    chk("rst_step_en", step_en, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_running", running, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_running", running, 1'b0);

    // Continuous up: 1..9 then wrap to 0 on the tenth pulse.
    mode = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("up_running", running, 1'b1);
    chk("up_start_no_step", step_en, 1'b0);
    for (int k = 1; k <= 10; k++)
      expect_step(4'(k % 10), (k == 10), 1'b1, "up");
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("up_stop_running", running, 1'b0);
    chk("up_stop_step_en", step_en, 1'b0);
    chk("up_stop_digit", digit, 4'd0);

    // Continuous down from 0: 9 (wrap), 8, 7.
    mode = 2'b01; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("dn_running", running, 1'b1);
    chk("dn_dir_at_start", dir, 1'b0);
    expect_step(4'd9, 1'b1, 1'b0, "dn9");
    expect_step(4'd8, 1'b0, 1'b0, "dn8");
    expect_step(4'd7, 1'b0, 1'b0, "dn7");
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("dn_stop_running", running, 1'b0);

    // Single steps up from 7 back to 0 (wrap on 9 -> 0).
    step_req = 1'b1; dir_in = 1'b1;
    cyc();
    chk("ss8_step_en", step_en, 1'b1);
    chk("ss8_digit", digit, 4'd8);
    chk("ss8_dir", dir, 1'b1);
    chk("ss8_wrap", wrap, 1'b0);
    cyc();
    chk("ss9_digit", digit, 4'd9);
    chk("ss9_wrap", wrap, 1'b0);
    cyc();
    step_req = 1'b0;
    chk("ss0_digit", digit, 4'd0);
    chk("ss0_wrap", wrap, 1'b1);
    cyc();
    chk("ss_idle_step_en", step_en, 1'b0);
    chk("ss_idle_wrap", wrap, 1'b0);

    // Ping-pong from 0: up to 9, back down to 0, then 1..3.
    mode = 2'b10; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("pp_dir_at_start", dir, 1'b1);
    for (int k = 1; k <= 8; k++)
      expect_step(4'(k), 1'b0, 1'b1, "pp_up");
    expect_step(4'd9, 1'b1, 1'b0, "pp_top");
    for (int k = 8; k >= 1; k--)
      expect_step(4'(k), 1'b0, 1'b0, "pp_dn");
    expect_step(4'd0, 1'b1, 1'b1, "pp_bottom");
    expect_step(4'd1, 1'b0, 1'b1, "pp_up1");
    expect_step(4'd2, 1'b0, 1'b1, "pp_up2");
    expect_step(4'd3, 1'b0, 1'b1, "pp_up3");

    // start/step_req ignored in RUN; stop on the count==DIV-1 edge suppresses the step.
    start = 1'b1; step_req = 1'b1; dir_in = 1'b0;
    cyc();
    start = 1'b0; step_req = 1'b0;
    chk("run_ign_step_en", step_en, 1'b0);
    chk("run_ign_digit", digit, 4'd3);
    cyc();
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_last_running", running, 1'b0);
    chk("stop_last_step_en", step_en, 1'b0);
    chk("stop_last_digit", digit, 4'd3);

    step_req = 1'b1; dir_in = 1'b0;
    cyc();
    step_req = 1'b0;
    chk("ssdn_step_en", step_en, 1'b1);
    chk("ssdn_digit", digit, 4'd2);
    chk("ssdn_dir", dir, 1'b0);
    chk("ssdn_wrap", wrap, 1'b0);

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_both_running", running, 1'b0);
    chk("ss_both_step_en", step_en, 1'b0);
    cyc();
    chk("ss_both_running2", running, 1'b0);
    chk("ss_both_digit", digit, 4'd2);

    // Up run: start+step_req mid-count must not disturb cadence.
    mode = 2'b00; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("cad_dir", dir, 1'b1);
    cyc();
    chk("cad_q1", step_en, 1'b0);
    start = 1'b1; step_req = 1'b1; dir_in = 1'b0;
    cyc();
    start = 1'b0; step_req = 1'b0;
    chk("cad_q2", step_en, 1'b0);
    cyc();
    chk("cad_q3", step_en, 1'b0);
    cyc();
    chk("cad_step_en", step_en, 1'b1);
    chk("cad_digit", digit, 4'd3);
    expect_step(4'd4, 1'b0, 1'b1, "cad4");
    expect_step(4'd5, 1'b0, 1'b1, "cad5");

    // Asynchronous reset between edges while step_en is high.
    #2 reset = 1'b1;
    #1;
    chk("arst_digit", digit, 4'd0);
    chk("arst_dir", dir, 1'b1);
    chk("arst_running", running, 1'b0);
    chk("arst_step_en", step_en, 1'b0);
    chk("arst_wrap", wrap, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("post_rst_step_en", step_en, 1'b0);
      chk("post_rst_running", running, 1'b0);
    end
    chk("post_rst_digit", digit, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_step_sequencer.md
Name: digit_step_sequencer

Overview:
- Controller that sequences the 0–9 up/down digit counter that drives HEX0.
- Replaces manual KEY[0] clocking and SW[0] direction with a prescaled step engine.
- Outputs a one-cycle step enable plus direction to the counter datapath, and keeps a shadow copy of the digit so it can detect boundaries.
- Supports continuous up, continuous down, ping-pong (auto-reverse at the ends) and single-step operation.

Parameters:
- DIV, 4, clock cycles per step while running (DIV >= 2).
- MAX_DIGIT, 9, highest digit value; the digit range is 0..MAX_DIGIT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  2  00 = up, 01 = down, 10 = ping-pong, 11 = reserved (treated as up). Sampled only with start.
- start  input  1  one-cycle request to begin running.
- stop  input  1  one-cycle request to halt running.
- step_req  input  1  one-cycle single-step request; honoured only in IDLE.
- dir_in  input  1  single-step direction: 1 = up, 0 = down.
- step_en  output  1  one-cycle pulse telling the counter to advance.
- dir  output  1  direction for the counter: 1 = up.
- digit  output  4  shadow of the counter value after the most recent step.
- running  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse on a wrap (up/down modes) or a reversal (ping-pong).

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - State = IDLE; digit = 0; dir = 1; step_en = 0; wrap = 0; running = 0; prescaler count = 0.
- States: IDLE and RUN. All outputs are registered.
- IDLE:
  - stop = 1 → stay in IDLE. stop has priority over start and over step_req.
  - Otherwise start = 1 → go to RUN:
    - Latch mode; clear the prescaler.
    - Set dir: up / reserved mode → 1; down → 0; ping-pong → 0 if digit == MAX_DIGIT, else 1.
  - Otherwise step_req = 1 → on the same edge: step_en = 1, dir = dir_in, digit updated by one step in direction dir_in, wrap set per the up/down rules below. Stay in IDLE.
  - If start and step_req are both high, start wins.
- RUN:
  - Prescaler increments every cycle.
  - On an edge where count == DIV-1: count → 0, step_en = 1, digit updated.
  - First step_en is high DIV cycles after the edge that sampled start; after that, one pulse every DIV cycles.
  - stop = 1 → IDLE on that edge, prescaler cleared, no step on that edge even if the count was DIV-1.
  - start and step_req are ignored in RUN. Changes on mode are ignored until the next start.
- step_en and wrap are high for exactly one cycle per step. They are never high in a cycle with no step.
- Digit arithmetic:
  - Up: MAX_DIGIT → 0, otherwise +1. wrap = 1 on the 0 result.
  - Down: 0 → MAX_DIGIT, otherwise −1. wrap = 1 on the MAX_DIGIT result.
- Ping-pong:
  - A step that lands on MAX_DIGIT while going up sets dir = 0 and wrap = 1 on the same edge.
  - A step that lands on 0 while going down sets dir = 1 and wrap = 1.
  - The digit never wraps in ping-pong.
- dir changes only on start, on a single step, or on a ping-pong reversal.
- digit holds its value across stop/start; only reset clears it.
- Reset asserted mid-RUN: immediate return to the reset values above. After reset is released, the block stays in IDLE until the next start.

Test Plan:
- Reset, mode=00, pulse start (DIV=4) → step_en pulses at cycles 4, 8, 12, …; digit goes 1, 2, …, 9, 0. wrap is high only with the 10th pulse (digit=0); dir=1 throughout.
- From digit=0, mode=01, start → first pulse gives digit=9 with wrap=1 and dir=0; next pulses give 8, 7 with wrap=0.
- From digit=0, mode=10, start → digits 1..9, with wrap=1 and dir→0 at 9; then 8..0, with wrap=1 and dir→1 at 0; then 1.
- Run up to digit=3, pulse stop on the cycle the count is DIV-1 → running=0, no step_en, digit stays 3. Then step_req with dir_in=0 → one step_en on the next edge, digit=2, dir=0.
- In IDLE, pulse start and stop together → stays IDLE, no step_en. In RUN, start and step_req together → ignored, pulse cadence unchanged.
- During RUN with digit=5, assert reset between clock edges → digit=0, dir=1, running=0, step_en=0 immediately. Release reset → no step_en until the next start.
